i2c_slave_responder: RTL and testbench
======================================

Name: i2c_slave_responder

Overview:
- Synthesizable I2C target (slave) responder; the opposite end of the master-side transfers described by i2c_globals_pkg (slave address, register address, data bytes, read/write).
- Oversamples SCL/SDA on the system clock and decodes START, repeated START and STOP.
- Serves a 7-bit addressed, register-indexed byte store: writes go into it, reads come out of it, with register-pointer auto-increment.
- Sits behind the pad/interface as the DUT-side responder for the I2C AVIP environment.

Parameters:
- DATA_LENGTH, 8, bits per data byte; taken from i2c_globals_pkg.
- REGISTER_ADDRESS_WIDTH, 8, register pointer width; taken from i2c_globals_pkg.
- REG_DEPTH, 16, number of byte registers; power of two, ≤ 2**REGISTER_ADDRESS_WIDTH.
- SYNC_STAGES, 2, synchronizer depth applied to scl_i and sda_i.

Ports:
- pclk  input  1  system clock; must be ≥ 8x the SCL frequency.
- areset_n  input  1  asynchronous, active-low reset.
- scl_i  input  1  SCL line as seen at the pad.
- sda_i  input  1  SDA line as seen at the pad.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- own_addr  input  7  this target's 7-bit slave address.
- busy  output  1  high from an address match until STOP.
- wr_valid  output  1  one-pclk pulse when a data byte is written to the store.
- wr_addr  output  REGISTER_ADDRESS_WIDTH  register index of the written byte.
- wr_data  output  DATA_LENGTH  the written byte.
- nack_count  output  8  count of address-matched transfers ended by a master NACK on read; saturates at 255.

Behaviour:
- Reset (async assert, sync deassert): sda_oe=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0, nack_count=0, register pointer=0, state=IDLE. Store contents are also cleared to 0.
- Input conditioning: SYNC_STAGES flops per line, then one delay flop for edge detection.
  - scl_rise/scl_fall are taken from the synchronized SCL.
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
- Bit timing: sample SDA on scl_rise. Update sda_oe on scl_fall, registered, so the total delay from the pad SCL edge is SYNC_STAGES+1 pclk.
- Bit order: MSB first for address, register address and data.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, WAIT_STOP.
  - IDLE: on START -> ADDR, bit counter = 0.
  - ADDR: shift 8 bits (7 address + R/W).
    - Match with R/W=0 -> ADDR_ACK, then REG.
    - Match with R/W=1 -> ADDR_ACK, then RDATA.
    - Mismatch -> WAIT_STOP, with sda_oe held at 0 throughout.
  - ADDR_ACK / REG_ACK / WDATA_ACK: drive sda_oe=1 from the scl_fall after bit 8 until the next scl_fall.
  - REG: shift 8 bits into the register pointer, keeping the low log2(REG_DEPTH) bits -> REG_ACK -> WDATA.
  - WDATA: shift 8 bits, then in a single pclk:
    - write store[ptr];
    - pulse wr_valid with wr_addr=ptr and wr_data=byte;
    - ptr = ptr+1, wrapping REG_DEPTH-1 -> 0;
    - go to WDATA_ACK, then back to WDATA.
  - RDATA: load store[ptr] at ADDR_ACK / RD_ACK completion. Drive sda_oe = ~bit on each scl_fall, 8 bits. ptr increments (with wrap) after the byte is sent. Then -> RD_ACK, with sda released.
  - RD_ACK: sample on scl_rise.
    - 0 (ACK) -> RDATA with the next byte.
    - 1 (NACK) -> WAIT_STOP; nack_count += 1 (saturating).
  - WAIT_STOP: sda_oe=0; wait for STOP or START.
- START in any state other than IDLE is a repeated START:
  - go to ADDR immediately; release sda_oe; reset the bit counter;
  - the register pointer is kept, so write-reg-then-Sr-read works.
- STOP in any state -> IDLE: sda_oe=0, busy=0; a partial byte is discarded and no write occurs.
- Simultaneous SCL and SDA edges within one sampled pclk: SCL-edge handling takes priority; START/STOP is evaluated only while SCL is stable high.
- busy: set at the ADDR_ACK entry on a match; cleared on STOP or at reset.

Decomposition:
- Add to i2c_globals_pkg:
  - the responder state enum i2c_slave_state_e;
  - the 7-bit address width constant SLAVE_ADDRESS_WIDTH_7_BITS = 7.
- Existing items reused from the package: read_write_e, DATA_LENGTH, REGISTER_ADDRESS_WIDTH.
- One sub-module: i2c_line_sync. It contains the synchronizers and edge detector and outputs scl_rise, scl_fall, start_det, stop_det and sda_s.
- The FSM, shifter and store live in i2c_slave_responder.

Test Plan:
- Write burst: own_addr=7'h50; START, 0xA0 (ACK), reg 0x03 (ACK), data 0x11, 0x22 (ACK each), STOP -> wr_valid pulses with (0x03,0x11) then (0x04,0x22); busy falls at STOP.
- Combined read: write reg 0x03, then Sr + 0xA1 -> bytes 0x11, 0x22 on SDA; master NACKs the second byte -> sda released, nack_count=1.
- Address mismatch: START + 0xA2 -> sda_oe stays 0 for the whole frame; no wr_valid; busy stays 0.
- Pointer wrap: REG_DEPTH=16; write starting at reg 0x0F with 3 bytes -> wr_addr sequence 0x0F, 0x00, 0x01.
- Abort: STOP after 4 data bits -> state IDLE, no wr_valid. areset_n asserted mid-ACK -> sda_oe=0 immediately (asynchronous).
- Timing: measure sda_oe assertion relative to the pad scl_i falling edge -> exactly SYNC_STAGES+1 pclk (3 for the defaults).

Source files
------------

// File: rtl/i2c_globals_pkg.sv
// Shared I2C constants and types for the master-side transfers and the target responder.
package i2c_globals_pkg;

   localparam int DATA_LENGTH                = 8;
   localparam int REGISTER_ADDRESS_WIDTH     = 8;
   localparam int SLAVE_ADDRESS_WIDTH_7_BITS = 7;

   typedef enum logic {
      WRITE = 1'b0,
      READ  = 1'b1
   } read_write_e;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      REG,
      REG_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RD_ACK,
      WAIT_STOP
   } i2c_slave_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes the pad SCL/SDA into pclk and decodes SCL edges plus START/STOP conditions.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic pclk,
   input  logic areset_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_d;
   logic                   r_sda_d;
   logic                   w_scl_s;
   logic                   w_scl_high;

   // Lines idle high, so the chains reset to 1 to avoid a phantom edge after reset.
   always_ff @(posedge pclk or negedge areset_n) begin
      if (!areset_n) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
         r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
         r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
      end
   end

   assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
   assign sda_s      = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_high = w_scl_s & r_scl_d;

   assign scl_rise  =  w_scl_s & ~r_scl_d;
   assign scl_fall  = ~w_scl_s &  r_scl_d;
   // SDA transitions only count as START/STOP while SCL is stable high on both samples.
   assign start_det = w_scl_high &  r_sda_d & ~sda_s;
   assign stop_det  = w_scl_high & ~r_sda_d &  sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target with a register-indexed byte store: register-pointer writes, auto-incrementing reads.
module i2c_slave_responder
   import i2c_globals_pkg::*;
#(
   parameter int REG_DEPTH   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                                  pclk,
   input  logic                                  areset_n,
   input  logic                                  scl_i,
   input  logic                                  sda_i,
   output logic                                  sda_oe,
   input  logic [SLAVE_ADDRESS_WIDTH_7_BITS-1:0] own_addr,
   output logic                                  busy,
   output logic                                  wr_valid,
   output logic [REGISTER_ADDRESS_WIDTH-1:0]     wr_addr,
   output logic [DATA_LENGTH-1:0]                wr_data,
   output logic [7:0]                            nack_count
);

   localparam int PTR_W = $clog2(REG_DEPTH);
   localparam int CNT_W = $clog2(DATA_LENGTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_LENGTH);

   logic w_scl_rise, w_scl_fall, w_start_det, w_stop_det, w_sda_s;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
      .pclk      (pclk),
      .areset_n  (areset_n),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .scl_rise  (w_scl_rise),
      .scl_fall  (w_scl_fall),
      .start_det (w_start_det),
      .stop_det  (w_stop_det),
      .sda_s     (w_sda_s)
   );

   i2c_slave_state_e             r_state, w_state;
   logic [CNT_W-1:0]             r_bit_cnt, w_bit_cnt;
   logic [DATA_LENGTH-1:0]       r_shift, w_shift;
   logic [PTR_W-1:0]             r_ptr, w_ptr;
   logic                         r_sda_oe, w_sda_oe;
   logic                         r_busy, w_busy;
   logic                         r_wr_valid, w_wr_valid;
   logic                         w_nack_inc;
   logic [REGISTER_ADDRESS_WIDTH-1:0] r_wr_addr;
   logic [DATA_LENGTH-1:0]       r_wr_data;
   logic [7:0]                   r_nack_count;
   logic [DATA_LENGTH-1:0]       r_store [REG_DEPTH];
   logic [DATA_LENGTH-1:0]       w_rd_byte;
   logic                         w_addr_match;

   assign w_rd_byte    = r_store[r_ptr];
   assign w_addr_match = (r_shift[DATA_LENGTH-1 -: SLAVE_ADDRESS_WIDTH_7_BITS] == own_addr);

   always_ff @(posedge pclk or negedge areset_n) begin
      if (!areset_n) begin
         r_state      <= IDLE;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_ptr        <= '0;
         r_sda_oe     <= 1'b0;
         r_busy       <= 1'b0;
         r_wr_valid   <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_nack_count <= '0;
         // NOTE: the store is reset because reads of never-written registers must return 0.
         r_store      <= '{default: '0};
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         r_state    <= w_state;
         r_bit_cnt  <= w_bit_cnt;
         r_shift    <= w_shift;
         r_ptr      <= w_ptr;
         r_sda_oe   <= w_sda_oe;
         r_busy     <= w_busy;
         r_wr_valid <= w_wr_valid;
         if (w_wr_valid) begin
            r_store[r_ptr] <= r_shift;
            r_wr_addr      <= REGISTER_ADDRESS_WIDTH'(r_ptr);
            r_wr_data      <= r_shift;
         end
         if (w_nack_inc && r_nack_count != 8'hFF) begin
            r_nack_count <= r_nack_count + 8'd1;
         end
      end
   end

   always_comb begin
      // NOTE: every next value defaults to its register first so no latch is inferred.
      w_state    = r_state;
      w_bit_cnt  = r_bit_cnt;
      w_shift    = r_shift;
      w_ptr      = r_ptr;
      w_sda_oe   = r_sda_oe;
      w_busy     = r_busy;
      w_wr_valid = 1'b0;
      w_nack_inc = 1'b0;

      if (w_stop_det) begin
         w_state  = IDLE;
         w_sda_oe = 1'b0;
         w_busy   = 1'b0;
      end else if (w_start_det) begin
         w_state   = ADDR;
         w_sda_oe  = 1'b0;
         w_bit_cnt = '0;
      end else begin
         case (r_state)
            ADDR, REG, WDATA: begin
               if (w_scl_rise && r_bit_cnt != CNT_FULL) begin
                  w_shift   = {r_shift[DATA_LENGTH-2:0], w_sda_s};
                  w_bit_cnt = r_bit_cnt + CNT_W'(1);
               end else if (w_scl_fall && r_bit_cnt == CNT_FULL) begin
                  // Byte complete: the ACK slot opens on this same SCL fall.
                  w_bit_cnt = '0;
                  w_sda_oe  = 1'b1;
                  if (r_state == ADDR) begin
                     if (w_addr_match) begin
                        w_state = ADDR_ACK;
                        w_busy  = 1'b1;
                     end else begin
                        w_state  = WAIT_STOP;
                        w_sda_oe = 1'b0;
                     end
                  end else if (r_state == REG) begin
                     w_state = REG_ACK;
                     w_ptr   = r_shift[PTR_W-1:0];
                  end else begin
                     w_state    = WDATA_ACK;
                     w_wr_valid = 1'b1;
                     w_ptr      = r_ptr + PTR_W'(1);
                  end
               end
            end
            ADDR_ACK: begin
               if (w_scl_fall) begin
                  w_bit_cnt = '0;
                  if (read_write_e'(r_shift[0]) == READ) begin
                     w_state  = RDATA;
                     w_shift  = w_rd_byte;
                     w_sda_oe = ~w_rd_byte[DATA_LENGTH-1];
                  end else begin
                     w_state  = REG;
                     w_sda_oe = 1'b0;
                  end
               end
            end
            REG_ACK, WDATA_ACK: begin
               if (w_scl_fall) begin
                  w_state   = WDATA;
                  w_sda_oe  = 1'b0;
                  w_bit_cnt = '0;
               end
            end
            RDATA: begin
               if (w_scl_rise && r_bit_cnt != CNT_FULL) begin
                  w_bit_cnt = r_bit_cnt + CNT_W'(1);
               end else if (w_scl_fall) begin
                  if (r_bit_cnt == CNT_FULL) begin
                     w_state   = RD_ACK;
                     w_sda_oe  = 1'b0;
                     w_ptr     = r_ptr + PTR_W'(1);
                     w_bit_cnt = '0;
                  end else begin
                     w_shift  = {r_shift[DATA_LENGTH-2:0], 1'b0};
                     w_sda_oe = ~r_shift[DATA_LENGTH-2];
                  end
               end
            end
            RD_ACK: begin
               if (w_scl_rise) begin
                  if (w_sda_s) begin
                     w_state    = WAIT_STOP;
                     w_nack_inc = 1'b1;
                  end else begin
                     w_bit_cnt = CNT_W'(1);
                  end
               end else if (w_scl_fall && r_bit_cnt == CNT_W'(1)) begin
                  w_state   = RDATA;
                  w_shift   = w_rd_byte;
                  w_sda_oe  = ~w_rd_byte[DATA_LENGTH-1];
                  w_bit_cnt = '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe     = r_sda_oe;
   assign busy       = r_busy;
   assign wr_valid   = r_wr_valid;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign nack_count = r_nack_count;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bit-banged I2C master against the responder, checked by a transaction-level store model.
module tb_i2c_slave_responder;

   localparam int Q = 50;

   logic       pclk     = 1'b0;
   logic       areset_n = 1'b0;
   logic       scl_i    = 1'b1;
   logic       m_sda    = 1'b1;
   logic [6:0] own_addr = 7'h50;
   wire        sda_line;
   logic       sda_oe, busy, wr_valid;
   logic [7:0] wr_addr, wr_data, nack_count;

   assign sda_line = m_sda & ~sda_oe;

   always #5 pclk = ~pclk;

   i2c_slave_responder dut (
      .pclk       (pclk),
      .areset_n   (areset_n),
      .scl_i      (scl_i),
      .sda_i      (sda_line),
      .sda_oe     (sda_oe),
      .own_addr   (own_addr),
      .busy       (busy),
      .wr_valid   (wr_valid),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .nack_count (nack_count)
   );

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t        exp_q[$];
   logic [7:0] obs_addr[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         wr_seen = 0;
   int         oe_viol = 0;
   bit         m_quiet = 1'b0;
   logic [7:0] m_store [16];
   int         m_ptr  = 0;
   int         m_nack = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Compare process: every write pulse must match the next write the model predicted.
   always @(negedge pclk) begin
      wr_t e;
      if (m_quiet && sda_oe) oe_viol++;
      if (areset_n && wr_valid) begin
         wr_seen++;
         obs_addr.push_back(wr_addr);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, required no write", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", {24'd0, wr_addr}, {24'd0, e.a});
            check("wr_data", {24'd0, wr_data}, {24'd0, e.d});
         end
      end
   end

   task automatic xfer_bit(input bit b, input bit measure, output logic r);
      time t0;
      int  n;
      m_sda = b;
      #Q scl_i = 1'b1;
      #Q r = sda_line;
      #Q scl_i = 1'b0;
      if (measure) begin
         t0 = $time;
         n  = 0;
         while (n < 10 && !sda_oe) begin
            @(posedge pclk);
            n++;
            #1;
         end
         check("ack_latency_pclk", n, 3);
         #(Q - ($time - t0));
      end else begin
         #Q;
      end
   endtask

   task automatic i2c_start();
      m_sda = 1'b1;
      #Q scl_i = 1'b1;
      #Q m_sda = 1'b0;
      #Q scl_i = 1'b0;
      #Q;
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      #Q scl_i = 1'b1;
      #Q m_sda = 1'b1;
      #Q;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit measure, output bit acked);
      logic r;
      for (int i = 7; i >= 0; i--) xfer_bit(b[i], measure && (i == 0), r);
      xfer_bit(1'b1, 1'b0, r);
      acked = (r == 1'b0);
   endtask

   task automatic recv_byte(input bit nack, output logic [7:0] d);
      logic r;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         xfer_bit(1'b1, 1'b0, r);
         d = {d[6:0], r};
      end
      xfer_bit(nack, 1'b0, r);
   endtask

   task automatic begin_write(input logic [7:0] rg);
      bit a;
      i2c_start();
      send_byte(8'hA0, 1'b0, a);
      check("addr_w_ack", a, 1);
      send_byte(rg, 1'b0, a);
      check("reg_ack", a, 1);
      m_ptr = int'(rg) % 16;
   endtask

   task automatic write_data(input logic [7:0] b);
      bit a;
      exp_q.push_back({8'(m_ptr), b});
      m_store[m_ptr] = b;
      m_ptr = (m_ptr + 1) % 16;
      send_byte(b, 1'b0, a);
      check("data_ack", a, 1);
   endtask

   task automatic begin_read();
      bit a;
      i2c_start();
      send_byte(8'hA1, 1'b0, a);
      check("addr_r_ack", a, 1);
   endtask

   task automatic read_data(input bit nack, output logic [7:0] d);
      logic [7:0] e;
      e = m_store[m_ptr];
      m_ptr = (m_ptr + 1) % 16;
      recv_byte(nack, d);
      check("rd_data", {24'd0, d}, {24'd0, e});
      if (nack && m_nack < 255) m_nack++;
   endtask

   initial begin
      logic [7:0] d0, d1;
      logic       r;
      bit         a;
      for (int i = 0; i < 16; i++) m_store[i] = 8'h00;

      #30;
      check("rst_sda_oe", sda_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_valid", wr_valid, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_nack_count", nack_count, 0);
      areset_n = 1'b1;
      #40;

      // Write burst at register 0x03.
      begin_write(8'h03);
      write_data(8'h11);
      write_data(8'h22);
      check("busy_in_frame", busy, 1);
      i2c_stop();
      #Q;
      check("busy_after_stop", busy, 0);
      check("burst_writes", wr_seen, 2);
      check("burst_addr1", obs_addr[1], 8'h04);
      check("burst_data1", wr_data, 8'h22);

      // Write-register then repeated-START read, NACK on the second byte.
      begin_write(8'h03);
      begin_read();
      read_data(1'b0, d0);
      read_data(1'b1, d1);
      check("rd_lit0", d0, 8'h11);
      check("rd_lit1", d1, 8'h22);
      check("sda_released_nack", sda_oe, 0);
      i2c_stop();
      check("nack_model", nack_count, m_nack);
      check("nack_lit", nack_count, 1);

      // Foreign address: the target must never touch SDA.
      m_quiet = 1'b1;
      i2c_start();
      send_byte(8'hA2, 1'b0, a);
      check("mismatch_no_ack", a, 0);
      send_byte(8'h55, 1'b0, a);
      check("mismatch_data_no_ack", a, 0);
      check("mismatch_busy", busy, 0);
      i2c_stop();
      m_quiet = 1'b0;
      check("mismatch_oe_cycles", oe_viol, 0);
      check("mismatch_writes", wr_seen, 2);

      // Pointer wrap from the last register.
      begin_write(8'h0F);
      write_data(8'h01);
      write_data(8'h02);
      write_data(8'h03);
      i2c_stop();
      check("wrap_a0", obs_addr[2], 8'h0F);
      check("wrap_a1", obs_addr[3], 8'h00);
      check("wrap_a2", obs_addr[4], 8'h01);

      // STOP after a partial data byte discards it.
      begin_write(8'h05);
      xfer_bit(1'b1, 1'b0, r);
      xfer_bit(1'b0, 1'b0, r);
      xfer_bit(1'b1, 1'b0, r);
      xfer_bit(1'b0, 1'b0, r);
      i2c_stop();
      #Q;
      check("abort_busy", busy, 0);
      check("abort_writes", wr_seen, 5);
      begin_write(8'h05);
      begin_read();
      read_data(1'b1, d0);
      check("abort_reg5_lit", d0, 8'h00);
      i2c_stop();
      check("nack_model2", nack_count, m_nack);

      // ACK latency measured from the pad SCL fall.
      i2c_start();
      send_byte(8'hA0, 1'b1, a);
      check("timing_ack", a, 1);
      i2c_stop();

      // Asynchronous reset while the target is driving the address ACK.
      i2c_start();
      for (int i = 7; i >= 0; i--) xfer_bit(((8'hA0 >> i) & 8'h01) != 0, 1'b0, r);
      check("ack_before_reset", sda_oe, 1);
      areset_n = 1'b0;
      #2;
      check("reset_sda_oe_async", sda_oe, 0);
      check("reset_busy_async", busy, 0);
      #8;
      m_sda = 1'b1;
      scl_i = 1'b1;
      #Q areset_n = 1'b1;
      #Q;
      for (int i = 0; i < 16; i++) m_store[i] = 8'h00;
      m_ptr  = 0;
      m_nack = 0;
      check("post_reset_nack", nack_count, 0);
      check("post_reset_wr_addr", wr_addr, 0);

      // Store contents are cleared by reset.
      begin_write(8'h03);
      begin_read();
      read_data(1'b1, d0);
      check("post_reset_reg3_lit", d0, 8'h00);
      i2c_stop();
      check("post_reset_nack_model", nack_count, m_nack);

      #(4 * Q);
      check("exp_q_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
